// File: rtl/cpu_periph_pkg.sv
// Shared definitions for the CPU peripheral slice: register map, TCON field
// positions and interrupt-controller state encodings.
package cpu_periph_pkg;

  localparam logic [31:0] ADDR_TH    = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL    = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON  = 32'h4000_0008;
  localparam logic [31:0] ADDR_ISTAT = 32'h4000_000C;

  localparam int TCON_TEN       = 0;
  localparam int TCON_TIE       = 1;
  localparam int TCON_TPEND     = 2;
  localparam int TCON_EMASK_LSB = 4;
  localparam int TCON_EPEND_LSB = 8;
  localparam int NUM_EXT_IRQ    = 4;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Assembles the TCON read view; bits not named here always read zero.
  function automatic logic [31:0] pack_tcon(
    input logic                   ten,
    input logic                   tie,
    input logic                   tpend,
    input logic [NUM_EXT_IRQ-1:0] emask,
    input logic [NUM_EXT_IRQ-1:0] epend
  );
    logic [31:0] v;
    v = '0;
    v[TCON_TEN]                         = ten;
    v[TCON_TIE]                         = tie;
    v[TCON_TPEND]                       = tpend;
    v[TCON_EMASK_LSB +: NUM_EXT_IRQ]    = emask;
    v[TCON_EPEND_LSB +: NUM_EXT_IRQ]    = epend;
    return v;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Free-running 32-bit timer: TL counts up while enabled and reloads from TH
// on wrap, emitting a one-cycle overflow pulse.
module irq_timer
  import cpu_periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ten_i,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic        ovf_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        at_max;

  assign at_max = (tl_q == TL_MAX);

  // A CPU write to TL wins over the reload, so it also suppresses the overflow.
  assign ovf_o = ten_i & at_max & ~tl_we_i;

  always_comb begin
    th_d = th_q;
    tl_d = tl_q;
    if (th_we_i) begin
      th_d = wdata_i;
    end
    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (ten_i) begin
      tl_d = at_max ? th_q : tl_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q <= '0;
      tl_q <= '0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
    end
  end

  assign th_o = th_q;
  assign tl_o = tl_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped timer plus interrupt request handshake with the CPU.
// Define IRQ_EXT_EN to enable the four external edge-triggered sources.
module irq_timer_ctrl
  import cpu_periph_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  input  logic                   pc31,
  input  logic [NUM_EXT_IRQ-1:0] irq_src,
  output logic                   irq
);

  logic th_we, tl_we, tcon_we;
  logic [31:0] th, tl;
  logic tmr_ovf;

  logic ten_q, ten_d;
  logic tie_q, tie_d;
  logic tpend_q, tpend_d;
  logic [NUM_EXT_IRQ-1:0] emask, epend;
  logic active;

  irq_state_e state_q, state_d;

  assign th_we   = wr && (addr == ADDR_TH);
  assign tl_we   = wr && (addr == ADDR_TL);
  assign tcon_we = wr && (addr == ADDR_TCON);

  irq_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .ten_i   (ten_q),
    .th_we_i (th_we),
    .tl_we_i (tl_we),
    .wdata_i (wdata),
    .th_o    (th),
    .tl_o    (tl),
    .ovf_o   (tmr_ovf)
  );

  // Pending bits: a new event in the same cycle beats a write-one-to-clear.
  always_comb begin
    ten_d   = ten_q;
    tie_d   = tie_q;
    tpend_d = tmr_ovf | (tpend_q & ~(tcon_we & wdata[TCON_TPEND]));
    if (tcon_we) begin
      ten_d = wdata[TCON_TEN];
      tie_d = wdata[TCON_TIE];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ten_q   <= 1'b0;
      tie_q   <= 1'b0;
      tpend_q <= 1'b0;
    end else begin
      ten_q   <= ten_d;
      tie_q   <= tie_d;
      tpend_q <= tpend_d;
    end
  end

`ifdef IRQ_EXT_EN
  logic [NUM_EXT_IRQ-1:0] emask_q, emask_d;
  logic [NUM_EXT_IRQ-1:0] epend_q, epend_d;
  logic [NUM_EXT_IRQ-1:0] src_q;
  logic [NUM_EXT_IRQ-1:0] epend_clr;

  assign epend_clr = tcon_we ? wdata[TCON_EPEND_LSB +: NUM_EXT_IRQ] : '0;

  always_comb begin
    emask_d = tcon_we ? wdata[TCON_EMASK_LSB +: NUM_EXT_IRQ] : emask_q;
    epend_d = (irq_src & ~src_q) | (epend_q & ~epend_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      emask_q <= '0;
      epend_q <= '0;
      src_q   <= '0;
    end else begin
      emask_q <= emask_d;
      epend_q <= epend_d;
      src_q   <= irq_src;
    end
  end

  assign emask = emask_q;
  assign epend = epend_q;
`else
  logic unused_irq_src;

  assign unused_irq_src = ^irq_src;
  assign emask          = '0;
  assign epend          = '0;
`endif

  assign active = (tpend_q & tie_q) | (|(epend & emask));

  // SERVICE only exits in user mode, so a re-request always sees an IDLE cycle first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (active && !pc31) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (pc31) begin
          state_d = ST_SERVICE;
        end else if (!active) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (!pc31) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign irq = (state_q == ST_REQ);

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      case (addr)
        ADDR_TH:    rdata = th;
        ADDR_TL:    rdata = tl;
        ADDR_TCON:  rdata = pack_tcon(ten_q, tie_q, tpend_q, emask, epend);
        ADDR_ISTAT: rdata = {29'b0, irq, state_q};
        default:    rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed and randomized checks of irq_timer_ctrl against a cycle-level
// reference model of the register map, timer and request handshake.
module tb_irq_timer_ctrl;

  localparam logic [31:0] A_TH    = 32'h4000_0000;
  localparam logic [31:0] A_TL    = 32'h4000_0004;
  localparam logic [31:0] A_TCON  = 32'h4000_0008;
  localparam logic [31:0] A_ISTAT = 32'h4000_000C;
`ifdef IRQ_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, pc31;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  irq_src;
  logic        irq;

  int checkCount = 0;
  int passCount  = 0;

  bit [31:0] mTh, mTl;
  bit        mTen, mTie, mTpend;
  bit [3:0]  mEmask, mEpend, mSrcPrev;
  int        mState;

  irq_timer_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .pc31    (pc31),
    .irq_src (irq_src),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mTh = 0; mTl = 0; mTen = 0; mTie = 0; mTpend = 0;
    mEmask = 0; mEpend = 0; mSrcPrev = 0; mState = 0;
  endtask

  function automatic bit modelActive();
    return (mTpend && mTie) || ((mEpend & mEmask) != 4'h0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == A_TH) v = mTh;
    else if (a == A_TL) v = mTl;
    else if (a == A_TCON) v = {20'h0, mEpend, mEmask, 1'b0, mTpend, mTie, mTen};
    else if (a == A_ISTAT) v = {29'h0, mState == 1, mState[1:0]};
    return v;
  endfunction

  // Advances the model by one clock using the inputs currently on the bus.
  task automatic modelStep();
    bit tlWr, thWr, tconWr, ovf, act;
    bit [3:0] rise, clr;
    act    = modelActive();
    tlWr   = wr && (addr == A_TL);
    thWr   = wr && (addr == A_TH);
    tconWr = wr && (addr == A_TCON);
    ovf    = mTen && (mTl == 32'hFFFF_FFFF) && !tlWr;
    rise   = EXT ? (irq_src & ~mSrcPrev) : 4'h0;
    clr    = tconWr ? wdata[11:8] : 4'h0;
    case (mState)
      0: if (act && !pc31) mState = 1;
      1: if (pc31) mState = 2; else if (!act) mState = 0;
      2: if (!pc31) mState = 0;
      default: mState = 0;
    endcase
    if (tlWr) mTl = wdata;
    else if (mTen) mTl = (mTl == 32'hFFFF_FFFF) ? mTh : mTl + 32'd1;
    if (thWr) mTh = wdata;
    mTpend = ovf || (mTpend && !(tconWr && wdata[2]));
    mEpend = rise | (mEpend & ~clr);
    if (tconWr) begin
      mTen = wdata[0];
      mTie = wdata[1];
      if (EXT) mEmask = wdata[7:4];
    end
    if (EXT) mSrcPrev = irq_src;
  endtask

  task automatic applyStimulus(input string tag, input logic rdV, input logic wrV,
                               input logic [31:0] addrV, input logic [31:0] wdataV,
                               input logic pc31V, input logic [3:0] srcV);
    rd = rdV; wr = wrV; addr = addrV; wdata = wdataV; pc31 = pc31V; irq_src = srcV;
    #2;
    checkOutput({tag, "_rdata"}, rdata, rdV ? modelRead(addrV) : 32'h0);
    checkOutput({tag, "_irq"}, {31'h0, irq}, {31'h0, mState == 1});
  endtask

  task automatic advanceClock();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic        w, r, p;
    logic [3:0]  s;
    int          sel;

    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    pc31 = 1'b0; irq_src = 4'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rd = 1'b1;
    addr = A_TH;    #1; checkOutput("rst_th", rdata, 32'h0);
    addr = A_TCON;  #1; checkOutput("rst_tcon", rdata, 32'h0);
    addr = A_ISTAT; #1; checkOutput("rst_istat", rdata, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Timer overflow raises TPEND and then the request.
    applyStimulus("wrTH", 0, 1, A_TH, 32'hFFFF_FFFC, 0, 0); advanceClock();
    applyStimulus("wrTL", 0, 1, A_TL, 32'hFFFF_FFFE, 0, 0); advanceClock();
    applyStimulus("wrTCON", 0, 1, A_TCON, 32'h3, 0, 0); advanceClock();
    applyStimulus("c1", 1, 0, A_TL, 0, 0, 0);
    checkOutput("ovf_tl_start", rdata, 32'hFFFF_FFFE); advanceClock();
    applyStimulus("c2", 1, 0, A_TL, 0, 0, 0);
    checkOutput("ovf_tl_max", rdata, 32'hFFFF_FFFF); advanceClock();
    applyStimulus("c3", 1, 0, A_TCON, 0, 0, 0);
    checkOutput("ovf_tpend", rdata, 32'h7);
    checkOutput("ovf_irq_pre", {31'h0, irq}, 32'h0);
    addr = A_TL; #1;
    checkOutput("ovf_tl_reload", rdata, 32'hFFFF_FFFC); advanceClock();
    applyStimulus("c4", 1, 0, A_ISTAT, 0, 0, 0);
    checkOutput("ovf_istat", rdata, 32'h5);
    checkOutput("ovf_irq", {31'h0, irq}, 32'h1); advanceClock();

    // Kernel entry, exit, and re-request after an idle user cycle.
    applyStimulus("k1", 1, 0, A_ISTAT, 0, 1, 0);
    checkOutput("svc_req", rdata, 32'h5); advanceClock();
    applyStimulus("k2", 1, 0, A_ISTAT, 0, 1, 0);
    checkOutput("svc_state", rdata, 32'h2);
    checkOutput("svc_irq", {31'h0, irq}, 32'h0); advanceClock();
    applyStimulus("k3", 1, 0, A_ISTAT, 0, 0, 0);
    checkOutput("svc_hold", rdata, 32'h2); advanceClock();
    applyStimulus("k4", 1, 0, A_ISTAT, 0, 0, 0);
    checkOutput("svc_idle", rdata, 32'h0);
    checkOutput("svc_idle_irq", {31'h0, irq}, 32'h0); advanceClock();
    applyStimulus("k5", 1, 0, A_ISTAT, 0, 0, 0);
    checkOutput("svc_rereq", rdata, 32'h5);
    checkOutput("svc_rereq_irq", {31'h0, irq}, 32'h1); advanceClock();
    applyStimulus("k6", 0, 1, A_TCON, 32'h2, 0, 0); advanceClock();
    applyStimulus("k7", 0, 1, A_TCON, 32'h4, 0, 0); advanceClock();
    applyStimulus("k8", 1, 0, A_TCON, 0, 0, 0);
    checkOutput("w1c_tcon", rdata, 32'h0); advanceClock();
    applyStimulus("k9", 1, 0, A_ISTAT, 0, 0, 0);
    checkOutput("w1c_istat", rdata, 32'h0); advanceClock();

    // W1C of TPEND in the same cycle as an overflow loses to the overflow.
    applyStimulus("p1", 0, 1, A_TL, 32'hFFFF_FFFE, 0, 0); advanceClock();
    applyStimulus("p2", 0, 1, A_TCON, 32'h3, 0, 0); advanceClock();
    applyStimulus("p3", 1, 0, A_TL, 0, 0, 0);
    checkOutput("prio_tl_fe", rdata, 32'hFFFF_FFFE); advanceClock();
    applyStimulus("p4", 1, 1, A_TCON, 32'h7, 0, 0);
    checkOutput("prio_tcon_pre", rdata, 32'h3); advanceClock();
    applyStimulus("p5", 1, 0, A_TCON, 0, 0, 0);
    checkOutput("prio_tpend_kept", rdata, 32'h7); advanceClock();

    // CPU write to TL at the wrap point beats the reload and sets no pending.
    applyStimulus("t1", 0, 1, A_TCON, 32'h4, 0, 0); advanceClock();
    applyStimulus("t2", 0, 1, A_TL, 32'hFFFF_FFFF, 0, 0); advanceClock();
    applyStimulus("t3", 0, 1, A_TCON, 32'h1, 0, 0); advanceClock();
    applyStimulus("t4", 1, 1, A_TL, 32'h10, 0, 0);
    checkOutput("tlwr_pre", rdata, 32'hFFFF_FFFF); advanceClock();
    applyStimulus("t5", 1, 0, A_TL, 0, 0, 0);
    checkOutput("tlwr_value", rdata, 32'h10); advanceClock();
    applyStimulus("t6", 1, 0, A_TCON, 0, 0, 0);
    checkOutput("tlwr_tpend", rdata, 32'h1); advanceClock();
    applyStimulus("t7", 0, 1, A_TCON, 32'h0, 0, 0); advanceClock();

`ifdef IRQ_EXT_EN
    applyStimulus("e1", 0, 1, A_TCON, 32'h20, 0, 4'h0); advanceClock();
    applyStimulus("e2", 1, 0, A_TCON, 0, 0, 4'h2);
    checkOutput("ext_mask", rdata, 32'h20); advanceClock();
    applyStimulus("e3", 1, 0, A_TCON, 0, 0, 4'h2);
    checkOutput("ext_epend", rdata, 32'h220); advanceClock();
    applyStimulus("e4", 1, 0, A_ISTAT, 0, 0, 4'h2);
    checkOutput("ext_istat", rdata, 32'h5);
    checkOutput("ext_irq", {31'h0, irq}, 32'h1); advanceClock();
    applyStimulus("e5", 0, 1, A_TCON, 32'h220, 0, 4'h2); advanceClock();
    applyStimulus("e6", 1, 0, A_TCON, 0, 0, 4'h2);
    checkOutput("ext_w1c", rdata, 32'h20); advanceClock();
    applyStimulus("e7", 1, 0, A_ISTAT, 0, 0, 4'h2);
    checkOutput("ext_idle", rdata, 32'h0);
    checkOutput("ext_idle_irq", {31'h0, irq}, 32'h0); advanceClock();
    applyStimulus("e8", 0, 1, A_TCON, 32'h0, 0, 4'h0); advanceClock();
`else
    applyStimulus("e1", 0, 1, A_TCON, 32'hFF0, 0, 4'h0); advanceClock();
    applyStimulus("e2", 0, 0, A_TCON, 0, 0, 4'hF); advanceClock();
    applyStimulus("e3", 1, 0, A_TCON, 0, 0, 4'hF);
    checkOutput("noext_tcon", rdata, 32'h0);
    checkOutput("noext_irq", {31'h0, irq}, 32'h0); advanceClock();
    applyStimulus("e4", 0, 0, A_TCON, 0, 0, 4'h0); advanceClock();
`endif

    // Asynchronous reset while a request is outstanding.
    applyStimulus("r1", 0, 1, A_TL, 32'hFFFF_FFFF, 0, 0); advanceClock();
    applyStimulus("r2", 0, 1, A_TCON, 32'h3, 0, 0); advanceClock();
    applyStimulus("r3", 0, 0, A_TL, 0, 0, 0); advanceClock();
    applyStimulus("r4", 1, 0, A_TCON, 0, 0, 0);
    checkOutput("areset_tcon_pre", rdata, 32'h7); advanceClock();
    applyStimulus("r5", 1, 0, A_ISTAT, 0, 0, 0);
    checkOutput("areset_irq_pre", {31'h0, irq}, 32'h1);
    wr = 1'b0;
    reset = 1'b0;
    #1; checkOutput("areset_irq", {31'h0, irq}, 32'h0);
    addr = A_TH;    #1; checkOutput("areset_th", rdata, 32'h0);
    addr = A_TL;    #1; checkOutput("areset_tl", rdata, 32'h0);
    addr = A_TCON;  #1; checkOutput("areset_tcon", rdata, 32'h0);
    addr = A_ISTAT; #1; checkOutput("areset_istat", rdata, 32'h0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized traffic with TL/TH values biased toward the wrap point.
    p = 1'b0;
    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = A_TH;
        1: a = A_TL;
        2: a = A_TCON;
        3: a = A_ISTAT;
        4: a = 32'h4000_0010;
        default: a = 32'h0000_0008;
      endcase
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (a == A_TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
      if (a == A_TH && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if (a == A_TCON && $urandom_range(0, 2) != 0) d[0] = 1'b1;
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = 4'($urandom);
      applyStimulus("rnd", r, w, a, d, p, s);
      advanceClock();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
